// File: rtl/reproductor_melodia.sv
// ----------------------------------------------------------------------------
// reproductor_melodia
// Melody sequencer for the tone generator's 7-bit one-hot key bus. It walks a
// fixed 16-entry song ROM, holds each key for dur*TICKS_PER_BEAT cycles and
// inserts GAP_TICKS cycles of silence after each entry. It pulses `done` when
// the end entry is reached.
//
// Optional feature: define REPRODUCTOR_LOOP_EN to add the `loop` input. With
// loop=1 the song restarts at entry 0 instead of finishing.
//
// Ports:
//   clk       in   1  system clock
//   reset     in   1  asynchronous active-high reset
//   start     in   1  start playback from entry 0 when idle
//   stop      in   1  abort playback (priority over start)
//   loop      in   1  (REPRODUCTOR_LOOP_EN only) restart instead of finishing
//   teclas    out  7  registered one-hot key, bit0=DO .. bit6=SI, 0 = silence
//   busy      out  1  high whenever not idle
//   done      out  1  one-cycle pulse when the end entry is reached
//   nota_idx  out  4  ROM address of the entry loaded/playing
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module reproductor_melodia #(
   parameter int unsigned TICKS_PER_BEAT = 12_500_000,
   parameter int unsigned GAP_TICKS      = 500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
`ifdef REPRODUCTOR_LOOP_EN
   input  logic       loop,
`endif
   output logic [6:0] teclas,
   output logic       busy,
   output logic       done,
   output logic [3:0] nota_idx
);

   localparam int unsigned KEY_W    = 7;
   localparam int unsigned IDX_W    = 4;
   localparam int unsigned DUR_W    = 4;
   localparam int unsigned CODE_W   = 3;
   localparam int unsigned NOTE_MAX = 15 * TICKS_PER_BEAT;
   localparam int unsigned CNT_MAX  = (NOTE_MAX > GAP_TICKS) ? NOTE_MAX : GAP_TICKS;
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
   localparam int unsigned GAP_LAST = (GAP_TICKS == 0) ? 0 : GAP_TICKS - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_NOTE,
      S_GAP,
      S_END
   } state_t;

   state_t               r_state;
   logic [KEY_W-1:0]     r_teclas;
   logic                 r_busy;
   logic                 r_done;
   logic [IDX_W-1:0]     r_idx;
   logic [DUR_W-1:0]     r_beats;
   logic [CNT_W-1:0]     r_cnt;

   state_t               w_state_nxt;
   logic [KEY_W-1:0]     w_teclas_nxt;
   logic [IDX_W-1:0]     w_idx_nxt;
   logic [DUR_W-1:0]     w_beats_nxt;
   logic [CNT_W-1:0]     w_cnt_nxt;

   logic [CODE_W+DUR_W-1:0] w_entry;
   logic [CODE_W-1:0]    w_code;
   logic [DUR_W-1:0]     w_dur;
   logic [KEY_W-1:0]     w_key;
   logic [CNT_W-1:0]     w_note_tgt;
   logic                 w_note_last;
   logic                 w_gap_last;
   logic                 w_loop;

   // Song ROM: {code, dur}; code 1..7 = DO..SI, dur 0 marks the end entry
   always_comb begin
      w_entry = '0;
      case (r_idx)
         4'd0:    w_entry = {3'd1, 4'd1};   // DO
         4'd1:    w_entry = {3'd1, 4'd1};   // DO
         4'd2:    w_entry = {3'd5, 4'd1};   // SOL
         4'd3:    w_entry = {3'd5, 4'd1};   // SOL
         4'd4:    w_entry = {3'd6, 4'd1};   // LA
         4'd5:    w_entry = {3'd6, 4'd1};   // LA
         4'd6:    w_entry = {3'd5, 4'd2};   // SOL
         4'd7:    w_entry = {3'd4, 4'd1};   // FA
         4'd8:    w_entry = {3'd4, 4'd1};   // FA
         4'd9:    w_entry = {3'd3, 4'd1};   // MI
         4'd10:   w_entry = {3'd3, 4'd1};   // MI
         4'd11:   w_entry = {3'd2, 4'd1};   // RE
         4'd12:   w_entry = {3'd2, 4'd1};   // RE
         4'd13:   w_entry = {3'd1, 4'd2};   // DO
         default: w_entry = {3'd0, 4'd0};   // end
      endcase
   end

   assign w_code = w_entry[CODE_W+DUR_W-1:DUR_W];
   assign w_dur  = w_entry[DUR_W-1:0];

   // Code 0 is a rest, so it maps to an all-zero key
   assign w_key = (w_code == '0) ? '0 : (KEY_W'(1) << (w_code - CODE_W'(1)));

   // Last NOTE cycle: counter started at 0 on the LOAD edge
   assign w_note_tgt  = CNT_W'(r_beats) * CNT_W'(TICKS_PER_BEAT) - CNT_W'(1);
   assign w_note_last = (r_cnt == w_note_tgt);
   assign w_gap_last  = (r_cnt == CNT_W'(GAP_LAST));

`ifdef REPRODUCTOR_LOOP_EN
   assign w_loop = loop;
`else
   assign w_loop = 1'b0;
`endif

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt  = r_state;
      w_teclas_nxt = r_teclas;
      w_idx_nxt    = r_idx;
      w_beats_nxt  = r_beats;
      w_cnt_nxt    = r_cnt;

      if (stop && (r_state != S_IDLE)) begin
         w_state_nxt  = S_IDLE;
         w_teclas_nxt = '0;
         w_idx_nxt    = '0;
         w_cnt_nxt    = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_teclas_nxt = '0;
               if (start && !stop) begin
                  w_state_nxt = S_LOAD;
                  w_idx_nxt   = '0;
                  w_cnt_nxt   = '0;
               end
            end

            S_LOAD: begin
               if (w_dur == '0) begin
                  w_state_nxt  = S_END;
                  w_teclas_nxt = '0;
               end else begin
                  w_state_nxt  = S_NOTE;
                  w_beats_nxt  = w_dur;
                  w_cnt_nxt    = '0;
                  w_teclas_nxt = w_key;
               end
            end

            S_NOTE: begin
               if (w_note_last) begin
                  w_teclas_nxt = '0;
                  w_cnt_nxt    = '0;
                  if (GAP_TICKS != 0) begin
                     w_state_nxt = S_GAP;
                  end else if (r_idx == '1) begin
                     // Table exhausted: never wrap mid-song
                     w_state_nxt = S_END;
                  end else begin
                     w_state_nxt = S_LOAD;
                     w_idx_nxt   = r_idx + IDX_W'(1);
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end

            S_GAP: begin
               w_teclas_nxt = '0;
               if (w_gap_last) begin
                  w_cnt_nxt = '0;
                  if (r_idx == '1) begin
                     w_state_nxt = S_END;
                  end else begin
                     w_state_nxt = S_LOAD;
                     w_idx_nxt   = r_idx + IDX_W'(1);
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end

            S_END: begin
               w_teclas_nxt = '0;
               w_idx_nxt    = '0;
               w_cnt_nxt    = '0;
               w_state_nxt  = w_loop ? S_LOAD : S_IDLE;
            end

            default: begin
               w_state_nxt  = S_IDLE;
               w_teclas_nxt = '0;
               w_idx_nxt    = '0;
               w_cnt_nxt    = '0;
            end
         endcase
      end
   end

   // State and registered outputs; done/busy follow the state being entered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_teclas <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_idx    <= '0;
         r_beats  <= '0;
         r_cnt    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_teclas <= w_teclas_nxt;
         r_busy   <= (w_state_nxt != S_IDLE);
         r_done   <= (w_state_nxt == S_END);
         r_idx    <= w_idx_nxt;
         r_beats  <= w_beats_nxt;
         r_cnt    <= w_cnt_nxt;
      end
   end

   assign teclas   = r_teclas;
   assign busy     = r_busy;
   assign done     = r_done;
   assign nota_idx = r_idx;

endmodule

// File: tb/tb_reproductor_melodia.sv
// ----------------------------------------------------------------------------
// tb_reproductor_melodia
// Scoreboard bench for reproductor_melodia with TICKS_PER_BEAT=4, GAP_TICKS=2.
// The stimulus process drives start/stop and advances a timeline model of the
// song (position t since playback began), pushing the expected outputs for the
// next cycle. A monitor pops one expectation per cycle and compares.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_reproductor_melodia;

   localparam int unsigned TPB = 4;
   localparam int unsigned GAP = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       stop;
`ifdef REPRODUCTOR_LOOP_EN
   logic       loop;
`endif
   logic [6:0] teclas;
   logic       busy;
   logic       done;
   logic [3:0] nota_idx;

   reproductor_melodia #(
      .TICKS_PER_BEAT (TPB),
      .GAP_TICKS      (GAP)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .stop     (stop),
`ifdef REPRODUCTOR_LOOP_EN
      .loop     (loop),
`endif
      .teclas   (teclas),
      .busy     (busy),
      .done     (done),
      .nota_idx (nota_idx)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0] teclas;
      logic       busy;
      logic       done;
      logic [3:0] idx;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_done_cnt = 0;
   int   act_done_cnt = 0;
   bit   mon_en = 1'b0;

   // Song as written: DO DO SOL SOL LA LA SOL FA FA MI MI RE RE DO, end, end
   int song_code [16] = '{1, 1, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 2, 1, 0, 0};
   int song_dur  [16] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2, 0, 0};

   // Model state: playing flag and cycle position since the start edge
   bit m_play = 1'b0;
   int m_t    = 0;

   // Expected outputs t cycles after the start edge, from the song timeline
   function automatic exp_t exp_at(input int t);
      exp_t e;
      int   r;
      int   len;
      e      = '0;
      e.busy = 1'b1;
      r      = t;
      for (int k = 0; k < 16; k++) begin
         if (song_dur[k] == 0) begin
            e.idx  = 4'(k);
            e.done = (r >= 1);
            return e;
         end
         len = 1 + song_dur[k] * int'(TPB) + int'(GAP);
         if (r < len) begin
            e.idx = 4'(k);
            if (r >= 1 && r <= song_dur[k] * int'(TPB) && song_code[k] != 0)
               e.teclas = 7'(1) << (song_code[k] - 1);
            return e;
         end
         r -= len;
      end
      e.idx  = 4'd15;
      e.done = 1'b1;
      return e;
   endfunction

   // Drive one cycle of inputs and queue the expectation after the next edge
   task automatic step(input bit st, input bit sp, input bit lp);
      exp_t e;
      start = st;
      stop  = sp;
`ifdef REPRODUCTOR_LOOP_EN
      loop  = lp;
`endif
      if (m_play) begin
         if (sp) begin
            m_play = 1'b0;
         end else if (exp_at(m_t).done) begin
`ifdef REPRODUCTOR_LOOP_EN
            if (lp) m_t = 0;
            else    m_play = 1'b0;
`else
            m_play = 1'b0;
            if (lp) m_t = 0;
`endif
         end else begin
            m_t++;
         end
      end else if (st && !sp) begin
         m_play = 1'b1;
         m_t    = 0;
      end
      e = m_play ? exp_at(m_t) : exp_t'('0);
      if (e.done) exp_done_cnt++;
      exp_q.push_back(e);
   endtask

   // Monitor: one comparison per cycle, sampled away from the clock edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (mon_en) begin
            if (done) act_done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_empty at %0t: no expectation queued", $time);
            end else begin
               e = exp_q.pop_front();
               if (teclas !== e.teclas || busy !== e.busy || done !== e.done || nota_idx !== e.idx) begin
                  errors++;
                  $display("FAIL cycle_outputs at %0t: got teclas=%b busy=%b done=%b idx=%0d, want teclas=%b busy=%b done=%b idx=%0d",
                           $time, teclas, busy, done, nota_idx, e.teclas, e.busy, e.done, e.idx);
               end
            end
         end
      end
   end

   task automatic check_reset_outputs(input string name);
      checks++;
      if (teclas !== 7'd0 || busy !== 1'b0 || done !== 1'b0 || nota_idx !== 4'd0) begin
         errors++;
         $display("FAIL %s: got teclas=%b busy=%b done=%b idx=%0d, want all zero",
                  name, teclas, busy, done, nota_idx);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
`ifdef REPRODUCTOR_LOOP_EN
      loop  = 1'b0;
`endif
      @(negedge clk);
      #1 check_reset_outputs("reset_state");
      @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b1;
      step(0, 0, 0);

      // Single start pulse, then the whole song with nothing else applied
      @(negedge clk); step(1, 0, 0);
      for (int i = 0; i < 115; i++) begin @(negedge clk); step(0, 0, 0); end

      // Stop during entry 3, idle 5 cycles, then replay
      @(negedge clk); step(1, 0, 0);
      for (int i = 0; i < 200 && m_t < 24; i++) begin @(negedge clk); step(0, 0, 0); end
      @(negedge clk); step(0, 1, 0);
      for (int i = 0; i < 5; i++) begin @(negedge clk); step(0, 0, 0); end
      @(negedge clk); step(1, 0, 0);
      for (int i = 0; i < 20; i++) begin @(negedge clk); step(0, 0, 0); end
      @(negedge clk); step(0, 1, 0);
      @(negedge clk); step(0, 0, 0);

      // start & stop together while idle, then start pulses while busy
      for (int i = 0; i < 3; i++) begin @(negedge clk); step(1, 1, 0); end
      @(negedge clk); step(1, 0, 0);
      for (int i = 0; i < 40; i++) begin @(negedge clk); step(i % 3 == 0, 0, 0); end
      // start held high across the end of the song
      for (int i = 0; i < 90; i++) begin @(negedge clk); step(1, 0, 0); end

      // Asynchronous reset in the middle of a note (entry 3)
      @(negedge clk); step(0, 1, 0);
      @(negedge clk); step(1, 0, 0);
      for (int i = 0; i < 200 && m_t < 23; i++) begin @(negedge clk); step(0, 0, 0); end
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      #1 check_reset_outputs("async_reset_mid_note");
      m_play = 1'b0;
      exp_q.push_back(exp_t'('0));
      @(negedge clk);
      reset = 1'b0;
      step(0, 0, 0);

`ifdef REPRODUCTOR_LOOP_EN
      // Looping playback, then leave loop low so the next END finishes
      @(negedge clk); step(1, 0, 1);
      for (int i = 0; i < 120; i++) begin @(negedge clk); step(0, 0, 1); end
      for (int i = 0; i < 120; i++) begin @(negedge clk); step(0, 0, 0); end
`endif

      // Randomised start/stop/loop traffic
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         step($urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1);
      end

      @(posedge clk);
      #4 mon_en = 1'b0;

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
      end
      checks++;
      if (act_done_cnt != exp_done_cnt) begin
         errors++;
         $display("FAIL done_pulse_count: got %0d, want %0d", act_done_cnt, exp_done_cnt);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
